// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one serial shift-add multiplier between two requesters.
// Sequences the multiplier load/run/release handshake and returns the product with an Ack.
module mult_share_sched #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Req0,
   input  logic [WIDTH-1:0]   A0,
   input  logic [WIDTH-1:0]   B0,
   input  logic               Req1,
   input  logic [WIDTH-1:0]   A1,
   input  logic [WIDTH-1:0]   B1,
   output logic               Ack0,
   output logic               Ack1,
   output logic               Err,
   output logic [2*WIDTH-1:0] Product,
   output logic               Busy,
   output logic               Owner,
   output logic [WIDTH-1:0]   Mul_S,
   output logic [WIDTH-1:0]   Mul_B,
   output logic               Mul_Load,
   output logic               Mul_Run,
   input  logic               Mul_Done,
   input  logic [2*WIDTH-1:0] Mul_Result
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StRelease, StAck} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               owner_q, owner_d;
   logic               prio_q, prio_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   mul_s_q, mul_s_d;
   logic [WIDTH-1:0]   mul_b_q, mul_b_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               win;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      prio_d    = prio_q;
      err_d     = err_q;
      mul_s_d   = mul_s_q;
      mul_b_d   = mul_b_q;
      res_d     = res_q;
      product_d = product_q;
      win       = 1'b0;
      case (state_q)
         StIdle: begin
            if (Req0 | Req1) begin
               // On a tie the round-robin pointer decides; otherwise the lone requester wins.
               win     = (Req0 & Req1) ? prio_q : Req1;
               owner_d = win;
               mul_s_d = win ? A1 : A0;
               mul_b_d = win ? B1 : B0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StRun;
         end
         StRun: begin
            if (Mul_Done) begin
               res_d   = Mul_Result;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = StRelease;
            end else if (cnt_q == CntLast) begin
               res_d   = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StRelease;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRelease: begin
            // Wait for the multiplier to drop out of Hold before acknowledging.
            if (!Mul_Done) begin
               product_d = res_q;
               state_d   = StAck;
            end else if (cnt_q == CntLast) begin
               product_d = res_q;
               err_d     = 1'b1;
               state_d   = StAck;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StAck: begin
            prio_d  = ~owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         prio_q    <= 1'b0;
         err_q     <= 1'b0;
         mul_s_q   <= '0;
         mul_b_q   <= '0;
         res_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         prio_q    <= prio_d;
         err_q     <= err_d;
         mul_s_q   <= mul_s_d;
         mul_b_q   <= mul_b_d;
         res_q     <= res_d;
         product_q <= product_d;
      end
   end

   assign Ack0     = (state_q == StAck) & ~owner_q;
   assign Ack1     = (state_q == StAck) & owner_q;
   assign Err      = (state_q == StAck) & err_q;
   assign Product  = product_q;
   assign Busy     = (state_q != StIdle);
   assign Owner    = owner_q;
   assign Mul_S    = mul_s_q;
   assign Mul_B    = mul_b_q;
   assign Mul_Load = (state_q == StLoad);
   assign Mul_Run  = (state_q == StRun);

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched with a behavioural serial-multiplier model.
module tb_mult_share_sched;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Req0 = 1'b0, Req1 = 1'b0;
   logic [7:0]  A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic        Ack0, Ack1, Err, Busy, Owner, Mul_Load, Mul_Run, Mul_Done;
   logic [15:0] Product, Mul_Result;
   logic [7:0]  Mul_S, Mul_B;

   mult_share_sched #(.WIDTH(8), .TIMEOUT(64)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(Req0), .A0(A0), .B0(B0),
      .Req1(Req1), .A1(A1), .B1(B1),
      .Ack0(Ack0), .Ack1(Ack1), .Err(Err), .Product(Product),
      .Busy(Busy), .Owner(Owner),
      .Mul_S(Mul_S), .Mul_B(Mul_B), .Mul_Load(Mul_Load), .Mul_Run(Mul_Run),
      .Mul_Done(Mul_Done), .Mul_Result(Mul_Result)
   );

   always #5 Clk = ~Clk;

   // Multiplier model: Done in the d_lat-th Run cycle, then held for 'hold' cycles after Run falls.
   int   d_lat = 17, hold = 1, rc = 0, sticky = 0;
   logic done_en = 1'b1;
   logic signed [15:0] prod;
   assign prod       = $signed(Mul_S) * $signed(Mul_B);
   assign Mul_Result = prod;
   assign Mul_Done   = done_en && ((Mul_Run && rc == d_lat - 1) || sticky != 0);

   always @(posedge Clk) begin
      rc <= Mul_Run ? rc + 1 : 0;
      if (Mul_Run && Mul_Done) sticky <= hold;
      else if (!Mul_Run && sticky > 0) sticky <= sticky - 1;
   end

   int errors = 0, checks = 0;
   logic [17:0] exp_q[$];

   function automatic void chk(string name, logic [31:0] got, logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endfunction

   int ack_total = 0, ack1_total = 0, load_total = 0;
   int run_cur = 0, last_run = 0, rel_cur = 0, last_rel = 0;

   // Monitor: pops the scoreboard on every Ack and tracks Load/Run/Release activity.
   always @(negedge Clk) begin
      logic [17:0] e;
      if (Mul_Load) load_total++;
      if (Mul_Run) run_cur++;
      else if (run_cur != 0) begin
         last_run = run_cur;
         run_cur  = 0;
         rel_cur  = 1;
      end else if (rel_cur != 0 && !(Ack0 | Ack1)) rel_cur++;
      if (Ack0 | Ack1) begin
         ack_total++;
         if (Ack1) ack1_total++;
         last_rel = rel_cur;
         rel_cur  = 0;
         if (exp_q.size() == 0) chk("unexpected_ack", {Ack0, Ack1}, 0);
         else begin
            e = exp_q.pop_front();
            chk("ack_resp", {Ack0, Ack1, Err, Product}, {~e[17], e[17], e[16], e[15:0]});
            chk("ack_owner", Owner, e[17]);
         end
      end
   end

   task automatic tick;
      @(negedge Clk);
      #1;
   endtask

   task automatic do_reset;
      Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
      tick; tick;
      Reset = 1'b0;
   endtask

   task automatic wait_acks(input int n, input int bound);
      int tgt;
      int k;
      tgt = ack_total + n;
      k = 0;
      while (ack_total < tgt && k < bound) begin
         tick;
         k++;
      end
      chk("ack_arrived", ack_total >= tgt, 1);
   endtask

   initial begin
      int l0, a1, a0, k;
      // Reset state
      do_reset;
      chk("rst_ctrl", {Ack0, Ack1, Err, Busy, Owner, Mul_Load, Mul_Run}, 0);
      chk("rst_product", Product, 0);
      chk("rst_ops", {Mul_S, Mul_B}, 0);

      // Single request: 7 * -3 = -21
      l0 = load_total; a1 = ack1_total;
      d_lat = 17; hold = 1; done_en = 1'b1;
      A0 = 8'h07; B0 = 8'hFD; Req0 = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'hFFEB});
      tick;
      Req0 = 1'b0;
      chk("t1_load", Mul_Load, 1);
      chk("t1_ops", {Mul_S, Mul_B}, 16'h07FD);
      wait_acks(1, 100);
      chk("t1_run_len", last_run, 17);
      chk("t1_loads", load_total - l0, 1);
      chk("t1_release", last_rel, 2);
      tick;
      chk("t1_idle", Busy, 0);
      chk("t1_no_ack1", ack1_total - a1, 0);

      // Contention: grants alternate 0,1,0,1
      do_reset;
      d_lat = 3; hold = 1;
      A0 = 8'd2; B0 = 8'd3; A1 = 8'd4; B1 = 8'd5;
      exp_q.push_back({1'b0, 1'b0, 16'd6});
      exp_q.push_back({1'b1, 1'b0, 16'd20});
      exp_q.push_back({1'b0, 1'b0, 16'd6});
      exp_q.push_back({1'b1, 1'b0, 16'd20});
      Req0 = 1'b1; Req1 = 1'b1;
      wait_acks(4, 200);
      Req0 = 1'b0; Req1 = 1'b0;
      tick;
      chk("t2_idle", Busy, 0);

      // Timeout: Done never arrives
      do_reset;
      done_en = 1'b0;
      A1 = 8'd9; B1 = 8'd9; Req1 = 1'b1;
      exp_q.push_back({1'b1, 1'b1, 16'h0000});
      tick;
      Req1 = 1'b0;
      wait_acks(1, 200);
      chk("t3_run_len", last_run, 64);
      tick;
      chk("t3_idle", Busy, 0);
      done_en = 1'b1;

      // Sticky done: Done held two cycles into RELEASE
      do_reset;
      d_lat = 5; hold = 2;
      l0 = load_total;
      A0 = 8'd3; B0 = 8'd5; Req0 = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'h000F});
      tick;
      Req0 = 1'b0;
      wait_acks(1, 100);
      chk("t4_release", last_rel, 3);
      chk("t4_loads", load_total - l0, 1);
      hold = 1;

      // Reset in the middle of RUN abandons the operation
      do_reset;
      d_lat = 20;
      A0 = 8'd1; B0 = 8'd1; Req0 = 1'b1;
      tick;
      Req0 = 1'b0;
      a0 = ack_total;
      k = 0;
      while (!Mul_Run && k < 10) begin
         tick;
         k++;
      end
      chk("t5_run_seen", Mul_Run, 1);
      repeat (4) tick;
      Reset = 1'b1;
      tick;
      chk("t5_rst_ctrl", {Ack0, Ack1, Err, Busy, Owner, Mul_Load, Mul_Run}, 0);
      chk("t5_rst_data", {Product, Mul_S, Mul_B}, 0);
      Reset = 1'b0;
      tick;
      chk("t5_no_ack", ack_total - a0, 0);
      d_lat = 4;
      A0 = 8'hFF; B0 = 8'hFF; Req0 = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'h0001});
      tick;
      Req0 = 1'b0;
      wait_acks(1, 100);

      // Operand capture: inputs change after the grant cycle
      do_reset;
      d_lat = 6;
      A0 = 8'h11; B0 = 8'h02; Req0 = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 16'h0022});
      tick;
      A0 = 8'h55; B0 = 8'h66; Req0 = 1'b0;
      tick; tick;
      chk("t6_ops_run", {Mul_S, Mul_B}, 16'h1102);
      wait_acks(1, 100);
      chk("t6_ops_ack", {Mul_S, Mul_B}, 16'h1102);

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
